id_ex_pipe_reg: RTL

Parametrised inter-stage pipeline register for the five-stage MIPS core, placed between decode/register-read and execute, optionally DEPTH slots deep to cover multi-cycle EX paths. It carries the instruction payload, register addresses and write controls, and decrements each in-flight instruction's Tnew (cycles until its result is produced) by one per advance, saturating at 0. It distinguishes hold (freeze), bubble (insert NOP) and flush (clear all slots), and squashes writes to $0. A combinational lookup port tells the hazard unit which in-flight instruction writes a queried register and its current Tnew.

---
 rtl/id_ex_pipe_reg.sv | 132 +++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: DEPTH chained slots with Tnew aging,
// hold/bubble/flush control and a hazard-unit lookup port.
module id_ex_pipe_reg #(
  parameter int DATA_W = 128,
  parameter int TNEW_W = 3,
  parameter int DEPTH = 1,
  parameter bit CLEAR_ON_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hold,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [4:0]        in_a1,
  input  logic [4:0]        in_a2,
  input  logic [4:0]        in_a3,
  input  logic              in_regwrite,
  input  logic              in_memwrite,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_a1,
  output logic [4:0]        out_a2,
  output logic [4:0]        out_a3,
  output logic              out_regwrite,
  output logic              out_memwrite,
  output logic [TNEW_W-1:0] out_tnew,
  input  logic [4:0]        q_addr,
  output logic              q_hit,
  output logic [TNEW_W-1:0] q_tnew,
  output logic [1:0]        q_slot,
  output logic [15:0]       bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [4:0]        a1;
    logic [4:0]        a2;
    logic [4:0]        a3;
    logic              regwrite;
    logic              memwrite;
    logic [TNEW_W-1:0] tnew;
  } slot_t;

  slot_t       slot_q [DEPTH];
  slot_t       slot_d [DEPTH];
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  function automatic logic [TNEW_W-1:0] dec(
    input logic [TNEW_W-1:0] t
  );
    return (t != '0) ? t - TNEW_W'(1) : '0;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < DEPTH; k++) begin
      slot_d[k] = slot_q[k];
    end
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_d[k] = '0;
      end
    end else if (!hold) begin
      for (int k = 1; k < DEPTH; k++) begin
        slot_d[k]      = slot_q[k-1];
        slot_d[k].tnew = dec(slot_q[k-1].tnew);
      end
      if (in_valid && !bubble) begin
        slot_d[0].valid    = 1'b1;
        slot_d[0].data     = in_data;
        slot_d[0].a1       = in_a1;
        slot_d[0].a2       = in_a2;
        slot_d[0].a3       = in_a3;
        // writes to $0 are squashed at capture
        slot_d[0].regwrite = in_regwrite && (in_a3 != 5'd0);
        slot_d[0].memwrite = in_memwrite;
        slot_d[0].tnew     = dec(in_tnew);
      end else begin
        slot_d[0] = '0;
        if (!CLEAR_ON_BUBBLE) begin
          slot_d[0].data = slot_q[0].data;
        end
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= slot_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

  // scan oldest to youngest so the youngest match wins
  always_comb begin
    q_hit  = 1'b0;
    q_tnew = '0;
    q_slot = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (slot_q[k].valid && slot_q[k].regwrite &&
          slot_q[k].a3 == q_addr && q_addr != 5'd0) begin
        q_hit  = 1'b1;
        q_tnew = slot_q[k].tnew;
        q_slot = 2'(k);
      end
    end
  end

  assign out_valid    = slot_q[DEPTH-1].valid;
  assign out_data     = slot_q[DEPTH-1].data;
  assign out_a1       = slot_q[DEPTH-1].a1;
  assign out_a2       = slot_q[DEPTH-1].a2;
  assign out_a3       = slot_q[DEPTH-1].a3;
  assign out_regwrite = slot_q[DEPTH-1].regwrite;
  assign out_memwrite = slot_q[DEPTH-1].memwrite;
  assign out_tnew     = slot_q[DEPTH-1].tnew;
  assign bubble_cnt   = cnt_q;

endmodule
